// File: rtl/led_chaser_pkg.sv
// rtl/led_chaser_pkg.sv - shared mode and direction encodings for the LED chaser
package led_chaser_pkg;

  localparam logic [1:0] MODE_RIGHT  = 2'd0;
  localparam logic [1:0] MODE_LEFT   = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_FILL   = 2'd3;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_t;

endpackage

// File: rtl/led_tick_div.sv
// rtl/led_tick_div.sv - enabled step prescaler, one step pulse every DIV enabled clocks
module led_tick_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic step
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign step = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_chaser.sv
// rtl/led_chaser.sv - parametrised LED pattern generator with right, left, bounce and fill modes
module led_chaser
  import led_chaser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] led,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] LSB_ONLY = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             step;
  dir_t             dir;
  dir_t             dir_nxt;
  logic [WIDTH-1:0] led_nxt;
  logic [WIDTH-1:0] start_pat;
  logic             one_hot;

  led_tick_div #(.DIV(DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .step  (step)
  );

  assign one_hot = (led != '0) && ((led & (led - 1'b1)) == '0);

  always_comb begin
    led_nxt   = led;
    dir_nxt   = dir;
    start_pat = (mode == MODE_LEFT) ? LSB_ONLY : MSB_ONLY;
    case (mode)
      MODE_RIGHT: led_nxt = (led == '0) ? MSB_ONLY : (led >> 1);
      MODE_LEFT:  led_nxt = (led == '0) ? LSB_ONLY : (led << 1);
      MODE_BOUNCE: begin
        // Anything that is not a single dot restarts the pass from the MSB end.
        if (!one_hot) begin
          led_nxt = MSB_ONLY;
          dir_nxt = DIR_RIGHT;
        end else if (dir == DIR_RIGHT) begin
          if (led[0]) begin
            led_nxt = led << 1;
            dir_nxt = DIR_LEFT;
          end else begin
            led_nxt = led >> 1;
          end
        end else begin
          if (led[WIDTH-1]) begin
            led_nxt = led >> 1;
            dir_nxt = DIR_RIGHT;
          end else begin
            led_nxt = led << 1;
          end
        end
      end
      default: led_nxt = (led == '1) ? '0 : ((led >> 1) | MSB_ONLY);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led  <= MSB_ONLY;
      dir  <= DIR_RIGHT;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (step) begin
        led  <= led_nxt;
        dir  <= dir_nxt;
        wrap <= (led_nxt == start_pat);
      end
    end
  end

endmodule

// File: tb/tb_led_chaser.sv
// tb/tb_led_chaser.sv - directed-vector bench for led_chaser across three size/prescale configurations
module tb_led_chaser;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1, en_a = 1'b0;
  logic [1:0]  mode_a = 2'd0;
  logic [7:0]  led_a;
  logic        wrap_a;
  logic        rst_b = 1'b1, en_b = 1'b0;
  logic [1:0]  mode_b = 2'd0;
  logic [7:0]  led_b;
  logic        wrap_b;
  logic        rst_c = 1'b1, en_c = 1'b0;
  logic [1:0]  mode_c = 2'd0;
  logic [11:0] led_c;
  logic        wrap_c;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  led_chaser #(.WIDTH(8), .DIV(1)) u_a (
    .clk(clk), .reset(rst_a), .en(en_a), .mode(mode_a), .led(led_a), .wrap(wrap_a)
  );
  led_chaser #(.WIDTH(8), .DIV(3)) u_b (
    .clk(clk), .reset(rst_b), .en(en_b), .mode(mode_b), .led(led_b), .wrap(wrap_b)
  );
  led_chaser #(.WIDTH(12), .DIV(2)) u_c (
    .clk(clk), .reset(rst_c), .en(en_c), .mode(mode_c), .led(led_c), .wrap(wrap_c)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a(input logic [1:0] m);
    rst_a = 1'b1; en_a = 1'b1; mode_a = m;
    tick();
    check_vec("a_rst_led", 32'(led_a), 32'h80);
    check_vec("a_rst_wrap", 32'(wrap_a), 32'h0);
    rst_a = 1'b0;
  endtask

  logic [7:0] right_seq [10] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00, 8'h80, 8'h40};
  logic [7:0] bnc_seq   [15] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                                 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40};
  logic [7:0] fill_seq  [10] = '{8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'h00, 8'h80, 8'hC0};
  logic [7:0] b_seq     [7]  = '{8'h80, 8'h80, 8'h40, 8'h40, 8'h40, 8'h20, 8'h20};

  initial begin
    int wraps;

    // RIGHT, DIV=1
    reset_a(2'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_vec($sformatf("a_right_led%0d", i), 32'(led_a), 32'(right_seq[i]));
      check_vec($sformatf("a_right_wrap%0d", i), 32'(wrap_a), (i == 8) ? 32'h1 : 32'h0);
    end

    // BOUNCE, DIV=1, period 14
    reset_a(2'd2);
    for (int i = 0; i < 15; i++) begin
      tick();
      check_vec($sformatf("a_bnc_led%0d", i), 32'(led_a), 32'(bnc_seq[i]));
      check_vec($sformatf("a_bnc_wrap%0d", i), 32'(wrap_a), (i == 13) ? 32'h1 : 32'h0);
    end

    // FILL, DIV=1
    reset_a(2'd3);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_vec($sformatf("a_fill_led%0d", i), 32'(led_a), 32'(fill_seq[i]));
      check_vec($sformatf("a_fill_wrap%0d", i), 32'(wrap_a), (i == 8) ? 32'h1 : 32'h0);
    end

    // FILL to F0, then BOUNCE reloads the multi-bit pattern
    tick();
    tick();
    check_vec("a_fill_f0", 32'(led_a), 32'hF0);
    mode_a = 2'd2;
    tick();
    check_vec("a_reload_led", 32'(led_a), 32'h80);
    check_vec("a_reload_wrap", 32'(wrap_a), 32'h1);
    tick();
    check_vec("a_reload_dir", 32'(led_a), 32'h40);
    check_vec("a_reload_wrap_clr", 32'(wrap_a), 32'h0);

    // LEFT from the reset pattern
    reset_a(2'd1);
    tick();
    check_vec("a_left_led0", 32'(led_a), 32'h00);
    check_vec("a_left_wrap0", 32'(wrap_a), 32'h0);
    tick();
    check_vec("a_left_led1", 32'(led_a), 32'h01);
    check_vec("a_left_wrap1", 32'(wrap_a), 32'h1);
    tick();
    check_vec("a_left_led2", 32'(led_a), 32'h02);
    check_vec("a_left_wrap2", 32'(wrap_a), 32'h0);
    en_a = 1'b0;

    // RIGHT, DIV=3, with an enable freeze in mid-phase
    rst_b = 1'b1; en_b = 1'b1; mode_b = 2'd0;
    tick();
    check_vec("b_rst_led", 32'(led_b), 32'h80);
    rst_b = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      check_vec($sformatf("b_div_led%0d", i), 32'(led_b), 32'(b_seq[i]));
      check_vec($sformatf("b_div_wrap%0d", i), 32'(wrap_b), 32'h0);
    end
    en_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_vec($sformatf("b_hold_led%0d", i), 32'(led_b), 32'h20);
      check_vec($sformatf("b_hold_wrap%0d", i), 32'(wrap_b), 32'h0);
    end
    en_b = 1'b1;
    tick();
    check_vec("b_resume_led0", 32'(led_b), 32'h20);
    tick();
    check_vec("b_resume_led1", 32'(led_b), 32'h10);
    wraps = 0;
    for (int i = 0; i < 18; i++) begin
      tick();
      wraps += int'(wrap_b);
    end
    check_vec("b_wrap_led", 32'(led_b), 32'h80);
    check_vec("b_wrap_now", 32'(wrap_b), 32'h1);
    check_vec("b_wrap_count", 32'(wraps), 32'd1);
    tick();
    check_vec("b_wrap_pulse", 32'(wrap_b), 32'h0);
    check_vec("b_wrap_hold", 32'(led_b), 32'h80);
    en_b = 1'b0;

    // WIDTH=12, DIV=2, reset landing on a step cycle
    rst_c = 1'b1; en_c = 1'b1; mode_c = 2'd0;
    tick();
    check_vec("c_rst_led", 32'(led_c), 32'h800);
    rst_c = 1'b0;
    tick();
    check_vec("c_led0", 32'(led_c), 32'h800);
    tick();
    check_vec("c_led1", 32'(led_c), 32'h400);
    tick();
    check_vec("c_led2", 32'(led_c), 32'h400);
    rst_c = 1'b1;
    tick();
    check_vec("c_midrst_led", 32'(led_c), 32'h800);
    check_vec("c_midrst_wrap", 32'(wrap_c), 32'h0);
    rst_c = 1'b0;
    tick();
    check_vec("c_post_led0", 32'(led_c), 32'h800);
    tick();
    check_vec("c_post_led1", 32'(led_c), 32'h400);
    check_vec("c_post_wrap", 32'(wrap_c), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
